// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 217;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Receive sequencer states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous serial line.
// Both stages reset to 1 so an idle (high) line never looks like a start bit.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d};
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent TX and RX sequencers sharing only clk/rst.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 txd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_data_valid,
  output logic                 tx_data_ack,
  input  logic                 rxd,
  output logic                 rx_data_fresh,
  output logic [DATA_BITS-1:0] rx_data
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  // Terminal counts: a full bit period, and the start-bit mid-point.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  tx_state_t            tx_state_q;
  logic [CNT_W-1:0]     tx_cnt_q;
  logic [IDX_W-1:0]     tx_idx_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 txd_q;
  logic                 tx_ack_q;

  // TX sequencer: accept a byte, then emit start, 8 data bits LSB first, stop.
  // A request pending at the end of the stop bit is taken straight into the
  // next start bit so held-valid streams run back-to-back with no idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      tx_ack_q   <= 1'b0;
    end else begin
      tx_ack_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          txd_q    <= 1'b1;
          tx_cnt_q <= '0;
          if (tx_data_valid) begin
            tx_shift_q <= tx_data;
            tx_ack_q   <= 1'b1;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            txd_q      <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == IDX_LAST) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_idx_q   <= tx_idx_q + IDX_W'(1);
              tx_shift_q <= tx_shift_q >> 1;
              txd_q      <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_data_valid) begin
              tx_shift_q <= tx_data;
              tx_ack_q   <= 1'b1;
              txd_q      <= 1'b0;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          txd_q      <= 1'b1;
        end
      endcase
    end
  end

  assign txd         = txd_q;
  assign tx_data_ack = tx_ack_q;

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  logic rxd_s;

  uart_sync u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  rx_state_t            rx_state_q;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [IDX_W-1:0]     rx_idx_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_fresh_q;
  // Set after a framing error: the line was low at the stop-bit mid-point,
  // and we must see it high again before hunting for the next start bit.
  logic                 rx_brk_q;

  // RX sequencer: find the start edge, confirm it at mid-bit, then sample
  // each following bit one full period later (i.e. at its own mid-point).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_fresh_q <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_fresh_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= '0;
          rx_brk_q <= 1'b0;
          if (!rxd_s) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            rx_idx_q <= '0;
            // A line already back high at mid-start was only a glitch.
            rx_state_q <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_idx_q == IDX_LAST) begin
              rx_brk_q   <= 1'b0;
              rx_state_q <= RX_STOP;
            end else begin
              rx_idx_q <= rx_idx_q + IDX_W'(1);
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_brk_q) begin
            if (rxd_s) begin
              rx_brk_q   <= 1'b0;
              rx_state_q <= RX_IDLE;
            end
          end else if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            if (rxd_s) begin
              // Leave at mid-stop so a following start bit is not missed.
              rx_data_q  <= rx_shift_q;
              rx_fresh_q <= 1'b1;
              rx_state_q <= RX_IDLE;
            end else begin
              rx_brk_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_fresh = rx_fresh_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: loopback and directly driven RX frames.
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int CPB = DEFAULT_CLKS_PER_BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       txd;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_data_ack;
  logic       rxd;
  logic       rx_data_fresh;
  logic [7:0] rx_data;

  logic loopback = 1'b1;
  logic rxd_drv  = 1'b1;
  assign rxd = loopback ? txd : rxd_drv;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .txd           (txd),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ack   (tx_data_ack),
    .rxd           (rxd),
    .rx_data_fresh (rx_data_fresh),
    .rx_data       (rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every fresh pulse is logged once per cycle it is high.
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (rx_data_fresh) rx_q.push_back(rx_data);
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_fresh;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, actual, cyc);
    end
  endtask

  // Bit k of a 10-bit 8N1 frame: start, data LSB first, stop.
  function automatic int frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 0;
    if (k >= 9) return 1;
    return (int'(b) >> (k - 1)) & 1;
  endfunction

  function automatic int rxq_at(input int idx);
    if (rx_q.size() > idx) return int'(rx_q[idx]);
    return -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where the ack is visible.
  task automatic send_byte(input logic [7:0] b, output int ack_cyc);
    int t;
    t = 0;
    tx_data = b;
    tx_data_valid = 1'b1;
    @(negedge clk);
    while (!tx_data_ack && t < 12 * CPB) begin
      @(negedge clk);
      t++;
    end
    check("ack_seen", int'(tx_data_ack), 1);
    ack_cyc = cyc;
    tx_data_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input string name);
    int t;
    t = 0;
    while (rx_q.size() < n && t < 14 * CPB) begin
      @(negedge clk);
      t++;
    end
    idle(2);
    check(name, rx_q.size(), n);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      rxd_drv = (k == 9) ? stop : logic'(frame_bit(b, k));
      repeat (CPB) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acks, ack_c, lat, t;
    int mism[10];
    int ack_at[4];
    logic [7:0] b2b[4];
    logic [7:0] exp_q[$];

    vecs[0] = '{8'h00, 1'b1, 1, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1, 8'hFF};
    vecs[2] = '{8'h5A, 1'b0, 0, 8'hFF};
    vecs[3] = '{8'h01, 1'b1, 1, 8'h01};
    vecs[4] = '{8'h80, 1'b1, 1, 8'h80};
    b2b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Reset state
    rst = 1'b1;
    idle(3);
    check("rst_txd", int'(txd), 1);
    check("rst_ack", int'(tx_data_ack), 0);
    check("rst_fresh", int'(rx_data_fresh), 0);
    check("rst_rx_data", int'(rx_data), 0);
    rst = 1'b0;
    idle(5);

    // Loopback 0x10: single ack pulse, one fresh pulse ~9.5..10 bits later
    base = rx_q.size();
    send_byte(8'h10, ack_c);
    acks = 1;
    repeat (30) begin
      @(negedge clk);
      if (tx_data_ack) acks++;
    end
    check("ack_pulse_width", acks, 1);
    t = 0;
    while (rx_q.size() <= base && t < 12 * CPB) begin
      @(negedge clk);
      t++;
    end
    lat = cyc - ack_c;
    check("rx_latency_in_range", int'(lat >= 9 * CPB && lat <= 10 * CPB + 3), 1);
    check("rx_0x10", rxq_at(base), 8'h10);
    idle(2 * CPB);
    check("rx_0x10_count", rx_q.size(), base + 1);
    check("rx_0x10_hold", int'(rx_data), 8'h10);

    // 0x55 waveform, cycle-exact against the frame model
    base = rx_q.size();
    send_byte(8'h55, ack_c);
    for (int k = 0; k < 10; k++) mism[k] = 0;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (int'(txd) != frame_bit(8'h55, k / CPB)) mism[k / CPB]++;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) check($sformatf("txd_0x55_bit%0d_mismatch_cycles", k), mism[k], 0);
    acks = 0;
    repeat (40) begin
      if (!txd) acks++;
      @(negedge clk);
    end
    check("txd_idle_high", acks, 0);
    wait_rx(base + 1, "rx_0x55_count");
    check("rx_0x55", rxq_at(base), 8'h55);

    // Back-to-back with valid held high
    base = rx_q.size();
    tx_data = b2b[0];
    tx_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      @(negedge clk);
      while (!tx_data_ack && t < 12 * CPB) begin
        @(negedge clk);
        t++;
      end
      ack_at[i] = cyc;
      if (i < 3) tx_data = b2b[i + 1];
      else tx_data_valid = 1'b0;
    end
    for (int i = 1; i < 4; i++) check($sformatf("b2b_ack_gap%0d", i), ack_at[i] - ack_at[i - 1], 10 * CPB);
    wait_rx(base + 4, "b2b_rx_count");
    for (int i = 0; i < 4; i++) check($sformatf("b2b_rx%0d", i), rxq_at(base + i), int'(b2b[i]));

    // Glitch on rxd, then a good frame
    idle(2 * CPB);
    loopback = 1'b0;
    rxd_drv = 1'b1;
    idle(CPB);
    base = rx_q.size();
    rxd_drv = 1'b0;
    idle(50);
    rxd_drv = 1'b1;
    idle(2 * CPB);
    check("glitch_no_fresh", rx_q.size(), base);
    drive_frame(8'hA5, 1'b1);
    idle(CPB);
    check("after_glitch_count", rx_q.size(), base + 1);
    check("after_glitch_rx", int'(rx_data), 8'hA5);

    // Framing error then good frame
    base = rx_q.size();
    drive_frame(8'h3C, 1'b0);
    idle(2 * CPB);
    check("ferr_no_fresh", rx_q.size(), base);
    check("ferr_rx_data_held", int'(rx_data), 8'hA5);
    drive_frame(8'h81, 1'b1);
    idle(CPB);
    check("after_ferr_count", rx_q.size(), base + 1);
    check("after_ferr_rx", int'(rx_data), 8'h81);

    // Table of directly driven frames
    for (int i = 0; i < 5; i++) begin
      base = rx_q.size();
      drive_frame(vecs[i].data, vecs[i].stop);
      idle(CPB / 2);
      check($sformatf("vec%0d_fresh", i), rx_q.size() - base, vecs[i].exp_fresh);
      check($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
    end

    // Random loopback bytes against a FIFO model
    loopback = 1'b1;
    idle(CPB);
    base = rx_q.size();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      idle($urandom_range(0, 40));
      send_byte(exp_q[i], ack_c);
      wait_rx(base + i + 1, $sformatf("rand%0d_count", i));
    end
    for (int i = 0; i < 5; i++) check($sformatf("rand%0d_rx", i), rxq_at(base + i), int'(exp_q[i]));

    // Reset during data bit 4, then a clean frame
    idle(2 * CPB);
    base = rx_q.size();
    send_byte(8'h99, ack_c);
    idle(5 * CPB + CPB / 2);
    rst = 1'b1;
    #1;
    check("midrst_txd", int'(txd), 1);
    check("midrst_ack", int'(tx_data_ack), 0);
    check("midrst_rx_data", int'(rx_data), 0);
    idle(3);
    rst = 1'b0;
    idle(12 * CPB);
    check("midrst_no_fresh", rx_q.size(), base);
    check("midrst_txd_idle", int'(txd), 1);
    send_byte(8'h42, ack_c);
    wait_rx(base + 1, "post_rst_count");
    check("post_rst_rx", rxq_at(base), 8'h42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
